// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage controller: FSM encoding, the
// bubble instruction, the sequential PC increment and an alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_OUT   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc.sv
// Program-counter register; loads the next-pc value every cycle.
// The architectural start address is applied by the controller, not here.
module fetch_ctrl_pc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_in,
    output logic [31:0] o_pc_out
);

    logic [31:0] r_pc;

    // PC storage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= 32'h0000_0000;
        end else begin
            r_pc <= i_pc_in;
        end
    end

    assign o_pc_out = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: sequences the PC, runs the req/ack read of
// instruction memory and presents fetched words to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_trap,
    input  logic        i_mret,
    input  logic [31:0] i_mepc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr
);

    import fetch_pkg::*;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_pend_pc;

    state_t      w_state_nxt;
    logic        w_req_nxt;
    logic [31:0] w_addr_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_if_instr_nxt;
    logic [31:0] w_pend_nxt;
    logic [31:0] w_pc;
    logic [31:0] w_pc_nxt;
    logic        w_event;
    logic [31:0] w_target;
    logic [31:0] w_pend_sel;

    fetch_ctrl_pc u_pc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pc_in  (w_pc_nxt),
        .o_pc_out (w_pc)
    );

    assign w_event = i_trap | i_mret | i_redirect_valid;

    // Redirect target by priority; a newer event replaces a parked target
    always_comb begin
        w_target = word_align(i_redirect_pc);
        if (i_trap) begin
            w_target = word_align(TRAP_VEC);
        end else if (i_mret) begin
            w_target = word_align(i_mepc);
        end else begin
            w_target = word_align(i_redirect_pc);
        end
        if (w_event) begin
            w_pend_sel = w_target;
        end else begin
            w_pend_sel = r_pend_pc;
        end
    end

    // Next-state, next-pc and next-output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = w_pc;
        w_pend_nxt     = r_pend_pc;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_valid_nxt    = r_valid;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;
        case (r_state)
            S_IDLE: begin
                w_valid_nxt    = 1'b0;
                w_if_instr_nxt = NOP_INSTR;
                w_req_nxt      = 1'b1;
                w_state_nxt    = S_REQ;
                if (w_event) begin
                    w_pc_nxt   = w_target;
                    w_addr_nxt = w_target;
                end else begin
                    w_pc_nxt   = word_align(RESET_ADDR);
                    w_addr_nxt = word_align(RESET_ADDR);
                end
            end
            S_REQ: begin
                if (i_imem_ack && w_event) begin
                    // Returned word belongs to the abandoned path
                    w_pc_nxt   = w_target;
                    w_addr_nxt = w_target;
                end else if (i_imem_ack) begin
                    w_if_instr_nxt = i_imem_rdata;
                    w_if_pc_nxt    = w_pc;
                    w_valid_nxt    = 1'b1;
                    w_pc_nxt       = w_pc + PC_STEP;
                    w_req_nxt      = 1'b0;
                    w_state_nxt    = S_OUT;
                end else if (w_event) begin
                    w_pend_nxt  = w_target;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_OUT: begin
                if (w_event) begin
                    w_valid_nxt    = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                    w_pc_nxt       = w_target;
                    w_addr_nxt     = w_target;
                    w_req_nxt      = 1'b1;
                    w_state_nxt    = S_REQ;
                end else if (!i_stall) begin
                    w_valid_nxt    = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                    w_addr_nxt     = w_pc;
                    w_req_nxt      = 1'b1;
                    w_state_nxt    = S_REQ;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            S_DRAIN: begin
                if (i_imem_ack) begin
                    w_pc_nxt    = w_pend_sel;
                    w_addr_nxt  = w_pend_sel;
                    w_state_nxt = S_REQ;
                end else begin
                    w_pend_nxt  = w_pend_sel;
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_req_nxt      = 1'b0;
                w_valid_nxt    = 1'b0;
                w_if_instr_nxt = NOP_INSTR;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= 32'h0000_0000;
            r_valid    <= 1'b0;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= NOP_INSTR;
            r_pend_pc  <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_valid    <= w_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_pend_pc  <= w_pend_nxt;
        end
    end

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_addr;
    assign o_if_valid  = r_valid;
    assign o_if_pc     = r_if_pc;
    assign o_if_instr  = r_if_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level fetch model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_A  = 32'h0000_0000;
    localparam logic [31:0] TRAP_A = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        mret;
    logic [31:0] mepc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_ADDR (RST_A),
        .TRAP_VEC   (TRAP_A),
        .NOP_INSTR  (NOP)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_trap           (trap),
        .i_mret           (mret),
        .i_mepc           (mepc),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_rdata     (imem_rdata),
        .o_if_valid       (if_valid),
        .o_if_pc          (if_pc),
        .o_if_instr       (if_instr)
    );

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int n_checks = 0;
    int n_err    = 0;

    // Model: is a fetch outstanding, for which address, will its data be
    // thrown away, and what is decode currently being shown.
    bit          m_boot;
    bit          m_req;
    logic [31:0] m_addr;
    bit          m_drop;
    logic [31:0] m_tgt;
    logic [31:0] m_seq;
    bit          m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;

    logic [31:0] seen_pc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("if_pc", if_pc, m_ifpc);
        chk("if_instr", if_instr, m_instr);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; stall = 1'b0; trap = 1'b0; mret = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; mepc = 32'h0; imem_ack = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        m_boot = 1'b1; m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
        m_ifpc = 32'h0; m_instr = NOP; m_addr = 32'h0;
        chk("rst_addr", imem_addr, 32'h0);
        check_all();
    endtask

    task automatic step(input logic st, input logic tr, input logic mr, input logic rv,
                        input logic [31:0] rpc, input logic [31:0] mpc, input logic ak);
        logic        ev;
        logic [31:0] tgt;
        stall = st; trap = tr; mret = mr; redirect_valid = rv;
        redirect_pc = rpc; mepc = mpc; imem_ack = ak;
        @(posedge clk);
        ev  = tr | mr | rv;
        tgt = tr ? TRAP_A : (mr ? (mpc & 32'hFFFF_FFFC) : (rpc & 32'hFFFF_FFFC));
        if (m_boot) begin
            m_boot = 1'b0; m_req = 1'b1;
            m_addr = ev ? tgt : RST_A;
        end else if (m_req) begin
            if (ak && (m_drop || ev)) begin
                m_addr = ev ? tgt : m_tgt;
                m_drop = 1'b0;
            end else if (ak) begin
                m_valid = 1'b1; m_ifpc = m_addr; m_instr = mem_word(m_addr);
                m_seq = m_addr + 32'd4;
                m_req = 1'b0;
            end else if (ev) begin
                m_drop = 1'b1; m_tgt = tgt;
            end
        end else if (ev || !st) begin
            m_valid = 1'b0; m_instr = NOP; m_req = 1'b1;
            m_addr = ev ? tgt : m_seq;
        end
        #1;
        check_all();
    endtask

    task automatic run(input logic st, input logic ak);
        step(st, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ak);
    endtask

    initial begin
        // Reset, then zero-wait fetches: addresses 0,4,8 and alternating valid
        do_reset(2);
        run(1'b0, 1'b0);
        chk("t1_first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 6; i++) begin
            run(1'b0, m_req);
            chk("t1_valid_alt", {31'd0, if_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (if_valid) seen_pc.push_back(if_pc);
        end
        chk("t1_count", seen_pc.size(), 32'd3);
        if (seen_pc.size() == 3) begin
            chk("t1_pc0", seen_pc[0], 32'h0);
            chk("t1_pc1", seen_pc[1], 32'h4);
            chk("t1_pc2", seen_pc[2], 32'h8);
        end

        // Wait states, then stall holding the presented instruction
        run(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run(1'b0, 1'b0);
            chk("t2_addr_stable", imem_addr, 32'hC);
        end
        run(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 1'b0);
            chk("t2_stall_pc", if_pc, 32'hC);
            chk("t2_stall_instr", if_instr, mem_word(32'hC));
        end
        run(1'b0, 1'b0);
        chk("t2_next_addr", imem_addr, 32'h10);

        // Redirect while the request at 0x10 is outstanding
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 1'b0);
        chk("t3_addr_held", imem_addr, 32'h10);
        run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        chk("t3_dropped", {31'd0, if_valid}, 32'd0);
        chk("t3_new_addr", imem_addr, 32'h200);

        // Priority: trap over mret over redirect, then mret over redirect
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h40, 1'b1);
        chk("t4_trap", imem_addr, 32'h100);
        run(1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h40, 1'b0);
        chk("t4_mret", imem_addr, 32'h40);

        // Alignment and wrap of the sequential increment
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1);
        chk("t5_align", imem_addr, 32'hFFFF_FFFC);
        run(1'b0, 1'b1);
        run(1'b0, 1'b0);
        chk("t5_wrap", imem_addr, 32'h0);

        // Reset while draining an abandoned request
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0);
        do_reset(1);
        run(1'b0, 1'b0);
        chk("t6_refetch", imem_addr, RST_A);
        run(1'b0, 1'b1);
        chk("t6_instr", if_instr, mem_word(RST_A));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset($urandom_range(2, 1));
            end else begin
                step(($urandom_range(3, 0) == 0),
                     ($urandom_range(15, 0) == 0),
                     ($urandom_range(11, 0) == 0),
                     ($urandom_range(5, 0) == 0),
                     $urandom, $urandom,
                     m_req && ($urandom_range(2, 0) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
